// File: rtl/cbus_arb_mux_if.sv
// Cache-bus bundle between the per-core L1 ports, the arbiter/mux and the shared L2 slave port.
// Modport master = the mux itself; modport slave = the cores plus L2 environment around it.
interface cbus_arb_mux_if #(
  parameter int NUM_MST = 4,
  parameter int UID_W   = 2,
  parameter int CMD_W   = 2,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_MST-1:0]        mst_req;
  logic [NUM_MST*CMD_W-1:0]  mst_cmd;
  logic [NUM_MST*ADDR_W-1:0] mst_addr;
  logic [NUM_MST*BE_W-1:0]   mst_data_be;
  logic [NUM_MST*DATA_W-1:0] mst_data;
  logic [NUM_MST-1:0]        mst_grnt;
  logic [NUM_MST-1:0]        mst_ack;
  logic [NUM_MST-1:0]        mst_rdy;
  logic [DATA_W-1:0]         mst_rdata;

  logic                      m_req;
  logic [CMD_W-1:0]          m_cmd;
  logic [ADDR_W-1:0]         m_addr;
  logic [UID_W-1:0]          m_uid;
  logic [BE_W-1:0]           m_data_be;
  logic [DATA_W-1:0]         m_data;
  logic                      m_ack;
  logic                      s_rdy;
  logic [UID_W-1:0]          s_uid;
  logic [DATA_W-1:0]         s_data;
  logic                      bad_uid;

  modport master (
    input  mst_req, mst_cmd, mst_addr, mst_data_be, mst_data, m_ack, s_rdy, s_uid, s_data,
    output mst_grnt, mst_ack, mst_rdy, mst_rdata,
           m_req, m_cmd, m_addr, m_uid, m_data_be, m_data, bad_uid
  );

  modport slave (
    output mst_req, mst_cmd, mst_addr, mst_data_be, mst_data, m_ack, s_rdy, s_uid, s_data,
    input  mst_grnt, mst_ack, mst_rdy, mst_rdata,
           m_req, m_cmd, m_addr, m_uid, m_data_be, m_data, bad_uid
  );
endinterface

// File: rtl/cbus_arb_mux.sv
// N-master to 1-slave cache-bus mux with registered round-robin arbiter and UID-routed returns.
// Define CBUS_ARB_MUX_RSP_REG_EN to register the response path (1-cycle latency).
module cbus_arb_mux #(
  parameter int NUM_MST = 4,
  parameter int UID_W   = 2,
  parameter int CMD_W   = 2,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32
) (
  input logic             clk,
  input logic             reset,
  cbus_arb_mux_if.master  bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  // rr_q doubles as the granted index while BUSY
  logic [UID_W-1:0]   rr_q, rr_d;
  logic [NUM_MST-1:0] grnt_q, grnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= UID_W'(NUM_MST - 1);
      grnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grnt_q  <= grnt_d;
    end
  end

  always_comb begin
    int   t;
    logic found;
    state_d = state_q;
    rr_d    = rr_q;
    grnt_d  = grnt_q;
    found   = 1'b0;
    t       = 0;
    case (state_q)
      IDLE: begin
        for (int k = 1; k <= NUM_MST; k++) begin
          t = int'(rr_q) + k;
          if (t >= NUM_MST) t = t - NUM_MST;
          if (!found && bus.mst_req[t]) begin
            found     = 1'b1;
            rr_d      = UID_W'(t);
            grnt_d    = '0;
            grnt_d[t] = 1'b1;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        // completion (ack with req) or abort (req dropped) both end the grant
        if (!bus.mst_req[rr_q] || bus.m_ack) begin
          state_d = IDLE;
          grnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic               m_req;
  logic [CMD_W-1:0]   m_cmd;
  logic [ADDR_W-1:0]  m_addr;
  logic [UID_W-1:0]   m_uid;
  logic [BE_W-1:0]    m_data_be;
  logic [DATA_W-1:0]  m_data;
  logic [NUM_MST-1:0] mst_ack;

  always_comb begin
    m_req     = 1'b0;
    m_cmd     = '0;
    m_addr    = '0;
    m_uid     = '0;
    m_data_be = '0;
    m_data    = '0;
    mst_ack   = '0;
    if (state_q == BUSY) begin
      m_req     = bus.mst_req[rr_q];
      m_cmd     = bus.mst_cmd[int'(rr_q)*CMD_W +: CMD_W];
      m_addr    = bus.mst_addr[int'(rr_q)*ADDR_W +: ADDR_W];
      m_uid     = rr_q;
      m_data_be = bus.mst_data_be[int'(rr_q)*BE_W +: BE_W];
      m_data    = bus.mst_data[int'(rr_q)*DATA_W +: DATA_W];
      mst_ack   = grnt_q & {NUM_MST{bus.m_ack}};
    end
  end

  assign bus.m_req     = m_req;
  assign bus.m_cmd     = m_cmd;
  assign bus.m_addr    = m_addr;
  assign bus.m_uid     = m_uid;
  assign bus.m_data_be = m_data_be;
  assign bus.m_data    = m_data;
  assign bus.mst_ack   = mst_ack;
  assign bus.mst_grnt  = grnt_q;

  // Return path: decoded purely from s_uid, independent of the arbiter
  logic [NUM_MST-1:0] rsp_rdy;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_bad;
  logic               bad_q;

  always_comb begin
    rsp_rdy = '0;
    for (int i = 0; i < NUM_MST; i++)
      rsp_rdy[i] = bus.s_rdy && (int'(bus.s_uid) == i);
    rsp_data = bus.s_rdy ? bus.s_data : '0;
    rsp_bad  = bus.s_rdy && (int'(bus.s_uid) >= NUM_MST);
  end

  always_ff @(posedge clk) begin
    if (reset)        bad_q <= 1'b0;
    else if (rsp_bad) bad_q <= 1'b1;
  end

`ifdef CBUS_ARB_MUX_RSP_REG_EN
  logic [NUM_MST-1:0] rdy_q;
  logic [DATA_W-1:0]  rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q   <= '0;
      rdata_q <= '0;
    end else begin
      rdy_q   <= rsp_rdy;
      rdata_q <= rsp_data;
    end
  end

  assign bus.mst_rdy   = rdy_q;
  assign bus.mst_rdata = rdata_q;
  assign bus.bad_uid   = bad_q;
`else
  assign bus.mst_rdy   = rsp_rdy;
  assign bus.mst_rdata = rsp_data;
  assign bus.bad_uid   = bad_q | rsp_bad;
`endif
endmodule

// File: tb/tb_cbus_arb_mux.sv
// Directed bench for cbus_arb_mux: 4-master instance for arbitration/routing, 3-master instance for bad UID.
module tb_cbus_arb_mux;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cbus_arb_mux_if #(.NUM_MST(4)) i4();
  cbus_arb_mux_if #(.NUM_MST(3)) i3();

  cbus_arb_mux #(.NUM_MST(4)) d4 (.clk(clk), .reset(reset), .bus(i4.master));
  cbus_arb_mux #(.NUM_MST(3)) d3 (.clk(clk), .reset(reset), .bus(i3.master));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    i4.mst_req = '0; i4.mst_cmd = '0; i4.mst_addr = '0; i4.mst_data_be = '0; i4.mst_data = '0;
    i4.m_ack = 1'b0; i4.s_rdy = 1'b0; i4.s_uid = '0; i4.s_data = '0;
    i3.mst_req = '0; i3.mst_cmd = '0; i3.mst_addr = '0; i3.mst_data_be = '0; i3.mst_data = '0;
    i3.m_ack = 1'b0; i3.s_rdy = 1'b0; i3.s_uid = '0; i3.s_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_grnt",  64'(i4.mst_grnt),  64'h0);
    chk("rst_mreq",  64'(i4.m_req),     64'h0);
    chk("rst_mcmd",  64'(i4.m_cmd),     64'h0);
    chk("rst_maddr", 64'(i4.m_addr),    64'h0);
    chk("rst_muid",  64'(i4.m_uid),     64'h0);
    chk("rst_ack",   64'(i4.mst_ack),   64'h0);
    chk("rst_rdy",   64'(i4.mst_rdy),   64'h0);
    chk("rst_rdata", 64'(i4.mst_rdata), 64'h0);
    chk("rst_bad4",  64'(i4.bad_uid),   64'h0);
    chk("rst_bad3",  64'(i3.bad_uid),   64'h0);

    // single request from master 0
    i4.mst_req = 4'b0001;
    i4.mst_cmd[1:0] = 2'd1;
    i4.mst_addr[29:0] = 30'h100;
    i4.mst_data_be[3:0] = 4'hf;
    i4.mst_data[31:0] = 32'h1111_1111;
    #1;
    chk("idle_mreq", 64'(i4.m_req), 64'h0);
    chk("idle_mcmd", 64'(i4.m_cmd), 64'h0);
    tick(); #1;
    chk("t1_grnt",  64'(i4.mst_grnt),  64'h1);
    chk("t1_mreq",  64'(i4.m_req),     64'h1);
    chk("t1_muid",  64'(i4.m_uid),     64'h0);
    chk("t1_maddr", 64'(i4.m_addr),    64'h100);
    chk("t1_mcmd",  64'(i4.m_cmd),     64'h1);
    chk("t1_mbe",   64'(i4.m_data_be), 64'hf);
    chk("t1_mdata", 64'(i4.m_data),    64'h1111_1111);
    chk("t1_ack0",  64'(i4.mst_ack),   64'h0);
    i4.m_ack = 1'b1;
    #1;
    chk("t1_ack", 64'(i4.mst_ack), 64'h1);
    tick();
    i4.mst_req = '0; i4.m_ack = 1'b0;
    #1;
    chk("t1_done", 64'(i4.mst_grnt), 64'h0);

    // all four requesting: 0,1,2,3,0 with one idle bubble between grants
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i4.mst_req = 4'hf; i4.m_ack = 1'b1;
    #1;
    chk("t2_rst_grnt", 64'(i4.mst_grnt), 64'h0);
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      tick(); #1;
      chk("t2_grnt", 64'(i4.mst_grnt), 64'(e));
      chk("t2_ack",  64'(i4.mst_ack),  64'(e));
      tick(); #1;
      chk("t2_gap",      64'(i4.mst_grnt), 64'h0);
      chk("t2_idle_ack", 64'(i4.mst_ack),  64'h0);
    end

    // rr_ptr -> 1, then 1001 pending: 3 wins before 0
    i4.mst_req = 4'b0010;
    tick(); #1;
    chk("t3_g1", 64'(i4.mst_grnt), 64'h2);
    i4.mst_req = 4'b1001;
    tick(); #1;
    chk("t3_gap", 64'(i4.mst_grnt), 64'h0);
    tick(); #1;
    chk("t3_g3", 64'(i4.mst_grnt), 64'h8);
    tick(); tick(); #1;
    chk("t3_g0", 64'(i4.mst_grnt), 64'h1);
    tick();
    i4.mst_req = '0; i4.m_ack = 1'b0;
    #1;
    chk("t3_done", 64'(i4.mst_grnt), 64'h0);

    // master 2 aborts before ack
    i4.mst_req = 4'b0100;
    tick(); #1;
    chk("t4_grnt", 64'(i4.mst_grnt), 64'h4);
    chk("t4_mreq", 64'(i4.m_req),    64'h1);
    chk("t4_muid", 64'(i4.m_uid),    64'h2);
    i4.mst_req = '0;
    #1;
    chk("t4_ab_mreq", 64'(i4.m_req),    64'h0);
    chk("t4_ab_ack",  64'(i4.mst_ack),  64'h0);
    chk("t4_ab_grnt", 64'(i4.mst_grnt), 64'h4);
    tick(); #1;
    chk("t4_clr", 64'(i4.mst_grnt), 64'h0);

    // response to master 3 while master 0 holds the bus
    i4.mst_req = 4'b0001;
    i4.mst_addr[29:0] = 30'h200;
    tick(); #1;
    chk("t5_grnt", 64'(i4.mst_grnt), 64'h1);
    i4.s_rdy = 1'b1; i4.s_uid = 2'd3; i4.s_data = 32'hDEAD_BEEF;
    #1;
`ifdef CBUS_ARB_MUX_RSP_REG_EN
    chk("t5_rdy_pre", 64'(i4.mst_rdy), 64'h0);
`else
    chk("t5_rdy",   64'(i4.mst_rdy),   64'h8);
    chk("t5_rdata", 64'(i4.mst_rdata), 64'hDEAD_BEEF);
`endif
    chk("t5_maddr", 64'(i4.m_addr), 64'h200);
    chk("t5_muid",  64'(i4.m_uid),  64'h0);
    chk("t5_mreq",  64'(i4.m_req),  64'h1);
    tick();
    i4.s_rdy = 1'b0; i4.s_uid = 2'd1; i4.s_data = '0;
    #1;
`ifdef CBUS_ARB_MUX_RSP_REG_EN
    chk("t5_rdy",   64'(i4.mst_rdy),   64'h8);
    chk("t5_rdata", 64'(i4.mst_rdata), 64'hDEAD_BEEF);
`else
    chk("t5_rdy_post",   64'(i4.mst_rdy),   64'h0);
    chk("t5_rdata_post", 64'(i4.mst_rdata), 64'h0);
`endif
    chk("t5_hold_grnt", 64'(i4.mst_grnt), 64'h1);
    i4.m_ack = 1'b1;
    tick();
    i4.mst_req = '0; i4.m_ack = 1'b0;
    i4.s_rdy = 1'b1; i4.s_uid = 2'd1; i4.s_data = 32'h1234_5678;
    #1;
    chk("t5_done", 64'(i4.mst_grnt), 64'h0);
`ifndef CBUS_ARB_MUX_RSP_REG_EN
    chk("t5i_rdy",   64'(i4.mst_rdy),   64'h2);
    chk("t5i_rdata", 64'(i4.mst_rdata), 64'h1234_5678);
`endif
    tick();
    i4.s_rdy = 1'b0;
    #1;
`ifdef CBUS_ARB_MUX_RSP_REG_EN
    chk("t5i_rdy",   64'(i4.mst_rdy),   64'h2);
    chk("t5i_rdata", 64'(i4.mst_rdata), 64'h1234_5678);
`endif
    tick(); #1;
    chk("t5_gate_rdy",   64'(i4.mst_rdy),   64'h0);
    chk("t5_gate_rdata", 64'(i4.mst_rdata), 64'h0);

    // reset while master 1 is granted
    i4.mst_req = 4'b0010;
    tick(); #1;
    chk("t6_grnt", 64'(i4.mst_grnt), 64'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rst_grnt", 64'(i4.mst_grnt), 64'h0);
    chk("t6_rst_mreq", 64'(i4.m_req),    64'h0);
    tick(); #1;
    chk("t6_regrant", 64'(i4.mst_grnt), 64'h2);
    i4.mst_req = '0; i4.m_ack = 1'b1;
    tick();
    i4.m_ack = 1'b0;

    // 3-master instance: uid 2 valid, uid 3 out of range and sticky
    i3.s_rdy = 1'b1; i3.s_uid = 2'd2; i3.s_data = 32'hCAFE_0002;
    #1;
`ifndef CBUS_ARB_MUX_RSP_REG_EN
    chk("t7_rdy2", 64'(i3.mst_rdy), 64'h4);
`endif
    chk("t7_bad0", 64'(i3.bad_uid), 64'h0);
    tick();
    i3.s_uid = 2'd3; i3.s_data = 32'h0000_0BAD;
    #1;
`ifdef CBUS_ARB_MUX_RSP_REG_EN
    chk("t7_rdy2", 64'(i3.mst_rdy), 64'h4);
    chk("t7_bad_lat", 64'(i3.bad_uid), 64'h0);
`else
    chk("t7_rdy3", 64'(i3.mst_rdy), 64'h0);
    chk("t7_bad",  64'(i3.bad_uid), 64'h1);
`endif
    tick();
    i3.s_rdy = 1'b0;
    #1;
    chk("t7_rdy_none", 64'(i3.mst_rdy), 64'h0);
    chk("t7_bad_set",  64'(i3.bad_uid), 64'h1);
    tick(); tick(); #1;
    chk("t7_bad_sticky", 64'(i3.bad_uid), 64'h1);
    reset = 1'b1;
    #1;
    chk("t7_bad_pre_edge", 64'(i3.bad_uid), 64'h1);
    tick();
    reset = 1'b0;
    #1;
    chk("t7_bad_clr", 64'(i3.bad_uid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
